// File: rtl/piezo_pkg.sv
// ----------------------------------------------------------------------------
// piezo_pkg
// Shared types and constants for the piezo tone sequencer.
//   state_t : sequencer FSM states (IDLE / NOTE / REST)
//   seq_t   : selected alarm sequence (FAST / BATT / STEER)
//   P_*     : note periods in clocks at 50 MHz
//   LEN_*   : number of notes in each sequence
// ----------------------------------------------------------------------------
package piezo_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    NOTE = 2'd1,
    REST = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    FAST  = 2'd0,
    BATT  = 2'd1,
    STEER = 2'd2
  } seq_t;

  localparam logic [20:0] P_G6 = 21'd31888;  // 1568 Hz
  localparam logic [20:0] P_C7 = 21'd23889;
  localparam logic [20:0] P_E7 = 21'd18961;
  localparam logic [20:0] P_G7 = 21'd15944;

  localparam int unsigned LEN_FAST  = 3;
  localparam int unsigned LEN_BATT  = 4;
  localparam int unsigned LEN_STEER = 4;

endpackage

// File: rtl/piezo_tone_seq_if.sv
// ----------------------------------------------------------------------------
// piezo_tone_seq_if
// Bundles the alarm/status condition inputs and the PWM-stage outputs of the
// tone sequencer.
//   too_fast, batt_low, en_steer : condition levels, synchronous to clk
//   max_cnt  [20:0]              : PWM period
//   duty     [19:0]              : PWM high time (0 = silence)
//   busy                         : a sequence (note or rest) is in progress
// master : the tone sequencer;  slave : the side supplying conditions and
// consuming the PWM settings.
// ----------------------------------------------------------------------------
interface piezo_tone_seq_if;

  logic        too_fast;
  logic        batt_low;
  logic        en_steer;
  logic [20:0] max_cnt;
  logic [19:0] duty;
  logic        busy;

  modport master (
    input  too_fast, batt_low, en_steer,
    output max_cnt, duty, busy
  );

  modport slave (
    output too_fast, batt_low, en_steer,
    input  max_cnt, duty, busy
  );

endinterface

// File: rtl/piezo_note_rom.sv
// ----------------------------------------------------------------------------
// piezo_note_rom
// Combinational note table: (seq, idx) -> PWM period, plus a flag marking the
// final note of the sequence.
//   seq      in  selected sequence
//   idx      in  note index within the sequence
//   period   out 21-bit note period in clocks
//   last_idx out high when idx is the last note of seq
// ----------------------------------------------------------------------------
module piezo_note_rom
  import piezo_pkg::*;
(
  input  seq_t        seq,
  input  logic [1:0]  idx,
  output logic [20:0] period,
  output logic        last_idx
);

  always_comb begin
    period   = '0;
    last_idx = 1'b1;
    case (seq)
      FAST: begin
        case (idx)
          2'd0:    period = P_G6;
          2'd1:    period = P_C7;
          default: period = P_E7;
        endcase
        last_idx = (idx >= 2'(LEN_FAST - 1));
      end
      BATT: begin
        case (idx)
          2'd0:    period = P_G7;
          2'd1:    period = P_E7;
          2'd2:    period = P_C7;
          default: period = P_G6;
        endcase
        last_idx = (idx >= 2'(LEN_BATT - 1));
      end
      STEER: begin
        case (idx)
          2'd0:    period = P_G6;
          2'd1:    period = P_C7;
          2'd2:    period = P_E7;
          default: period = P_G7;
        endcase
        last_idx = (idx >= 2'(LEN_STEER - 1));
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/piezo_tone_seq.sv
// ----------------------------------------------------------------------------
// piezo_tone_seq
// Turns overspeed / battery-low / steering-enabled conditions into timed note
// sequences for the downstream piezo PWM generator.
//   clk      in  system clock (50 MHz)
//   rst_n    in  asynchronous active-low reset
//   bus      master modport of piezo_tone_seq_if:
//              too_fast/batt_low/en_steer in, max_cnt/duty/busy out
// Parameters:
//   NOTE_CYC  clocks per note (>= 2)
//   REST_CYC  clocks of silence between repeats (>= 2)
// ----------------------------------------------------------------------------
module piezo_tone_seq
  import piezo_pkg::*;
#(
  parameter int unsigned NOTE_CYC = 8388608,
  parameter int unsigned REST_CYC = 33554432
) (
  input  logic              clk,
  input  logic              rst_n,
  piezo_tone_seq_if.master  bus
);

  localparam int unsigned CW = $clog2((NOTE_CYC > REST_CYC) ? NOTE_CYC : REST_CYC);
  localparam logic [CW-1:0] NOTE_LAST = CW'(NOTE_CYC - 1);
  localparam logic [CW-1:0] REST_LAST = CW'(REST_CYC - 1);

  state_t         state, state_nx;
  seq_t           seq, seq_nx;
  logic [1:0]     idx, idx_nx;
  logic [CW-1:0]  cnt, cnt_nx;
  logic           last_q, last_nx;
  logic [20:0]    max_cnt_q, max_cnt_nx;
  logic [19:0]    duty_q, duty_nx;
  logic           busy_q, busy_nx;

  // Conditions are sampled once; every decision uses the sampled copy, which
  // gives the one-clock request-to-note latency.
  logic           fast_q, batt_q, steer_q;

  logic           any_req, start;
  seq_t           req_seq;
  logic [20:0]    period_nx;
  logic           rom_last;

  // Addressed by the next (seq, idx) so period and last flag are registered
  // alongside the state they belong to.
  piezo_note_rom u_rom (
    .seq      (seq_nx),
    .idx      (idx_nx),
    .period   (period_nx),
    .last_idx (rom_last)
  );

  assign any_req = fast_q | batt_q | steer_q;
  assign req_seq = fast_q ? FAST : (batt_q ? BATT : STEER);

  always_comb begin
    state_nx = state;
    seq_nx   = seq;
    idx_nx   = idx;
    cnt_nx   = cnt + CW'(1);
    start    = 1'b0;
    case (state)
      IDLE: begin
        cnt_nx = '0;
        start  = any_req;
      end
      NOTE: begin
        if (fast_q && seq != FAST) begin
          start = 1'b1;
        end else if (cnt == NOTE_LAST) begin
          cnt_nx = '0;
          if (!last_q)                  idx_nx   = idx + 2'd1;
          else if (seq == FAST && fast_q) idx_nx = '0;
          else                          state_nx = REST;
        end
      end
      REST: begin
        if (fast_q && seq != FAST) begin
          start = 1'b1;
        end else if (cnt == REST_LAST) begin
          cnt_nx = '0;
          if (any_req) start    = 1'b1;
          else         state_nx = IDLE;
        end
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end
    endcase
    if (start) begin
      state_nx = NOTE;
      seq_nx   = req_seq;
      idx_nx   = '0;
      cnt_nx   = '0;
    end
  end

  always_comb begin
    max_cnt_nx = max_cnt_q;
    duty_nx    = '0;
    last_nx    = last_q;
    busy_nx    = (state_nx != IDLE);
    if (state_nx == NOTE) begin
      max_cnt_nx = period_nx;
      duty_nx    = period_nx[20:1];
      last_nx    = rom_last;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      seq       <= FAST;
      idx       <= '0;
      cnt       <= '0;
      last_q    <= 1'b0;
      max_cnt_q <= '0;
      duty_q    <= '0;
      busy_q    <= 1'b0;
      fast_q    <= 1'b0;
      batt_q    <= 1'b0;
      steer_q   <= 1'b0;
    end else begin
      state     <= state_nx;
      seq       <= seq_nx;
      idx       <= idx_nx;
      cnt       <= cnt_nx;
      last_q    <= last_nx;
      max_cnt_q <= max_cnt_nx;
      duty_q    <= duty_nx;
      busy_q    <= busy_nx;
      fast_q    <= bus.too_fast;
      batt_q    <= bus.batt_low;
      steer_q   <= bus.en_steer;
    end
  end

  assign bus.max_cnt = max_cnt_q;
  assign bus.duty    = duty_q;
  assign bus.busy    = busy_q;

endmodule

// File: doc/piezo_tone_seq.md
Name: piezo_tone_seq

Overview:
- Upstream stage of the piezo PWM generator; drives its 21-bit max_cnt (period) and 20-bit duty inputs.
- Turns Segway alarm/status conditions into timed note sequences.
- Chooses the note period and holds each note for a fixed duration.
- Outputs silence by driving duty = 0; the PWM stage then holds its output low.

Parameters:
- NOTE_CYC, 8388608, clocks per note (~168 ms at 50 MHz); must be >= 2.
- REST_CYC, 33554432, clocks of silence between repeats of a sequence; must be >= 2.
- P_G6, 31888, period in clocks for G6 (1568 Hz at 50 MHz).
- P_C7, 23889, period for C7.
- P_E7, 18961, period for E7.
- P_G7, 15944, period for G7.

Ports:
- clk  in  1  system clock, 50 MHz.
- rst_n  in  1  asynchronous active-low reset.
- too_fast  in  1  overspeed condition; level, synchronous to clk.
- batt_low  in  1  battery-low condition; level.
- en_steer  in  1  steering-enabled status; level.
- max_cnt  out  21  PWM period; registered.
- duty  out  20  PWM high time; registered.
- busy  out  1  high while any sequence (note or rest) is in progress.

Behaviour:
- Reset (asynchronous, active-low), all registered:
  - state = IDLE, max_cnt = 0, duty = 0, busy = 0.
  - Note index and duration counter cleared.
- States: IDLE, NOTE, REST. A 2-bit seq register records the selected sequence: FAST, BATT or STEER.
- Priority on selection: too_fast > batt_low > en_steer.
- IDLE:
  - If any input is high at edge N, then from edge N+1: state = NOTE, seq latched, idx = 0, counter = 0, busy = 1.
  - max_cnt/duty load note 0 at that same edge (1-cycle latency).
- Sequences, in idx order:
  - FAST: G6, C7, E7.
  - BATT: G7, E7, C7, G6.
  - STEER: G6, C7, E7, G7.
- Output values:
  - In NOTE: max_cnt = period of current note; duty = max_cnt >> 1 (truncated to 20 bits, ~50%).
  - In REST and IDLE: max_cnt holds its last value and duty = 0.
- NOTE advance: the counter increments every clock. When counter == NOTE_CYC-1:
  - Counter goes to 0.
  - If idx < last, idx increments.
  - Otherwise:
    - FAST with too_fast still high: idx = 0, staying in NOTE with no rest.
    - FAST with too_fast low, or BATT/STEER: go to REST.
- REST: lasts REST_CYC clocks. At its end:
  - If the highest-priority active input maps to any sequence, restart NOTE idx 0 with that sequence.
  - Otherwise go to IDLE and drop busy on that edge.
- Preemption:
  - too_fast rising while seq != FAST (in NOTE or REST) aborts on the next edge and enters NOTE, seq = FAST, idx 0, counter 0.
  - batt_low and en_steer never preempt; they are only evaluated at IDLE or at REST end.
- An input dropping mid-sequence does not stop it. The current sequence always completes, except FAST, which simply stops looping.
- Counter widths come from $clog2 of the max of NOTE_CYC and REST_CYC. There is no wrap-around beyond the terminal compare.
- Reset asserted mid-note returns to IDLE with duty = 0 immediately (asynchronously).

Decomposition:
- Package piezo_pkg holds:
  - State enum (IDLE/NOTE/REST).
  - Seq enum (FAST/BATT/STEER).
  - Note period localparams and sequence lengths.
- Sub-module piezo_note_rom: combinational lookup (seq, idx) -> 21-bit period, plus a last_idx flag.
- The FSM, counters and output registers stay in piezo_tone_seq.

Test Plan (all with NOTE_CYC = 16, REST_CYC = 32):
- Reset:
  - Stimulus: assert rst_n = 0 mid-note.
  - Required: max_cnt = 0, duty = 0, busy = 0 with no clock edge; IDLE after release with all inputs low.
- STEER:
  - Stimulus: pulse en_steer for 1 cycle.
  - Required: max_cnt sequence 31888, 23889, 18961, 15944, each for 16 clocks, with duty = max_cnt >> 1 (15944, 11944, 9480, 7972).
  - Required after the notes: duty = 0 for 32 clocks, then busy = 0.
- FAST loop:
  - Stimulus: hold too_fast for 100 clocks.
  - Required: G6/C7/E7 repeat with no rest between cycles.
  - Required after release: the current cycle finishes, then REST, then IDLE.
- Preemption:
  - Stimulus: batt_low sequence running at idx 1 (E7); raise too_fast.
  - Required: next edge max_cnt = 31888 and the counter restarts, so the first FAST note lasts a full 16 clocks.
- Priority:
  - Stimulus: batt_low and en_steer asserted on the same cycle from IDLE.
  - Required: BATT runs (first max_cnt = 15944).
  - Required, with both inputs still high at REST end: BATT repeats.
- Latency:
  - Stimulus: en_steer sampled high at edge N.
  - Required: busy = 1 and max_cnt = 31888 after edge N+1, not earlier.
